dds_key_ctrl: RTL
=================

// Module: dds_key_ctrl
// PURPOSE
//  Front-panel controller for the dual-channel DDS. Consumes three debounced, active-low
//  key levels (mode/up/down) and maintains the DDS configuration: per-channel frequency
//  word, per-channel waveform select and channel-B phase offset. Sits between the key
//  debouncers and the two phase accumulators; emits a one-cycle update strobe per change.
// PARAMETERS
//  FW_WIDTH    32         frequency-word width
//  FREQ_INIT   32'd42950  reset frequency word, both channels
//  FREQ_STEP   32'd4295   increment/decrement per up/down event
//  FREQ_MAX    32'd429497 upper frequency-word limit (inclusive); lower limit is FREQ_STEP
//  PH_WIDTH    12         phase-offset width
//  PH_STEP     12'd256    phase increment per event (wraps)
//  LONG_PRESS  24'd5000000  hold cycles before auto-repeat starts
//  REPEAT      24'd1000000  cycles between auto-repeat events
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         asynchronous reset, active low
//  key_mode     in   1         debounced mode key, 0 = pressed
//  key_up       in   1         debounced up key, 0 = pressed
//  key_down     in   1         debounced down key, 0 = pressed
//  freq_word_a  out  FW_WIDTH  channel A frequency word
//  freq_word_b  out  FW_WIDTH  channel B frequency word
//  wave_sel_a   out  2         channel A waveform: 0 sine,1 square,2 triangle,3 saw
//  wave_sel_b   out  2         channel B waveform, same coding
//  phase_b      out  PH_WIDTH  channel B phase offset relative to A
//  edit_field   out  3         field under edit (FSM state code, for display)
//  cfg_update   out  1         1-cycle pulse when any config output changed
// BEHAVIOUR
//  - One clock; reset is asynchronous, active low. Reset: freq_word_a/b=FREQ_INIT, wave_sel_a/b=0,
//    phase_b=0, edit_field=0 (F_A), cfg_update=0, edge registers=1 (released), repeat counter=0.
//  - Press event: key register was 1, key input now 0 (falling edge). Release produces no event.
//  - FSM states (edit_field): 0 F_A, 1 W_A, 2 F_B, 3 W_B, 4 P_B; codes 5-7 unreachable, recover to F_A.
//    mode press: advance F_A->W_A->F_B->W_B->P_B->F_A. No config change, no cfg_update.
//  - up/down events act on current field:
//    F_x: +/-FREQ_STEP, saturate at FREQ_MAX / FREQ_STEP (clamp, never wrap).
//    W_x: +/-1 modulo 4 (3+1=0, 0-1=3).  P_B: +/-PH_STEP modulo 2**PH_WIDTH.
//  - Latency: event detected in cycle N -> new value and cfg_update=1 visible after edge N+1.
//    cfg_update asserts only if the value actually changed (clamped step at limit: no pulse).
//  - Priority: mode event beats up/down in same cycle (field advances, value untouched).
//    up and down both held/pressed together: no action, repeat counter cleared.
//  - Auto-repeat: exactly one of up/down held low and other released; counter runs; at
//    LONG_PRESS issue one event, then every REPEAT cycles while held. Release or second key
//    clears counter. mode never repeats. Field change while held continues repeat in new field.
//  - Counter saturates; no overflow. Reset mid-hold: all state to reset values; key still low
//    after reset generates no event (edge regs reset to released, so first release needed? no:
//    edge regs =1, so a held key DOES produce one press event on the first cycle after reset).
// TESTING
//  Use LONG_PRESS=8, REPEAT=4, FREQ_INIT=500, FREQ_STEP=100, FREQ_MAX=1000.
//  1 reset, single up pulse in F_A -> freq_word_a 500->600, one cfg_update 2 cycles after edge.
//  2 mode x5 -> edit_field 1,2,3,4,0; outputs unchanged; cfg_update never asserted.
//  3 F_A, hold up 30 cycles -> 600 at edge+2, repeats at 8,12,16,20... clamps at 1000, pulses stop.
//  4 W_B (mode x3), down once -> wave_sel_b 0->3; P_B, down once -> phase_b 0->3840.
//  5 up+down pressed same cycle -> no change; mode+up same cycle -> field advances only.
//  6 assert rst_n low mid-hold of up -> all outputs reset immediately; after release of rst_n
//    with up still low -> exactly one event, then repeat after LONG_PRESS.

Source files
------------

// File: rtl/dds_key_ctrl.sv
// Front-panel key controller for the dual-channel DDS: turns debounced active-low keys
// into edits of frequency words, waveform selects and channel-B phase, with auto-repeat.
module dds_key_ctrl #(
   parameter int                  FW_WIDTH   = 32,
   parameter logic [FW_WIDTH-1:0] FREQ_INIT  = FW_WIDTH'(42950),
   parameter logic [FW_WIDTH-1:0] FREQ_STEP  = FW_WIDTH'(4295),
   parameter logic [FW_WIDTH-1:0] FREQ_MAX   = FW_WIDTH'(429497),
   parameter int                  PH_WIDTH   = 12,
   parameter logic [PH_WIDTH-1:0] PH_STEP    = PH_WIDTH'(256),
   parameter logic [23:0]         LONG_PRESS = 24'd5000000,
   parameter logic [23:0]         REPEAT     = 24'd1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_mode,
   input  logic                key_up,
   input  logic                key_down,
   output logic [FW_WIDTH-1:0] freq_word_a,
   output logic [FW_WIDTH-1:0] freq_word_b,
   output logic [1:0]          wave_sel_a,
   output logic [1:0]          wave_sel_b,
   output logic [PH_WIDTH-1:0] phase_b,
   output logic [2:0]          edit_field,
   output logic                cfg_update
);

   localparam logic [2:0] F_A = 3'd0;
   localparam logic [2:0] W_A = 3'd1;
   localparam logic [2:0] F_B = 3'd2;
   localparam logic [2:0] W_B = 3'd3;
   localparam logic [2:0] P_B = 3'd4;

   logic                r_key_mode, r_key_up, r_key_down;
   logic [23:0]         r_cnt;
   logic                r_ev_mode, r_ev_up, r_ev_dn;
   logic [FW_WIDTH-1:0] r_freq_a, r_freq_b;
   logic [1:0]          r_wave_a, r_wave_b;
   logic [PH_WIDTH-1:0] r_phase_b;
   logic [2:0]          r_field;
   logic                r_upd;

   logic                w_mode_press, w_up_press, w_dn_press, w_one_held, w_rep;
   logic                w_up_act, w_dn_act, w_chg;
   logic [FW_WIDTH-1:0] w_fa, w_fb;
   logic [1:0]          w_wa, w_wb;
   logic [PH_WIDTH-1:0] w_ph;
   logic [2:0]          w_field;

   function automatic logic [FW_WIDTH-1:0] freq_inc(input logic [FW_WIDTH-1:0] f);
      if (f >= FREQ_MAX - FREQ_STEP) return FREQ_MAX;
      return f + FREQ_STEP;
   endfunction

   function automatic logic [FW_WIDTH-1:0] freq_dec(input logic [FW_WIDTH-1:0] f);
      if (f < FREQ_STEP + FREQ_STEP) return FREQ_STEP;
      return f - FREQ_STEP;
   endfunction

   assign w_mode_press = r_key_mode & ~key_mode;
   assign w_up_press   = r_key_up & ~key_up;
   assign w_dn_press   = r_key_down & ~key_down;
   assign w_one_held   = key_up ^ key_down;
   // A fresh press restarts the hold timer, so a repeat can never coincide with a press
   assign w_rep        = w_one_held & ~w_up_press & ~w_dn_press & (r_cnt == LONG_PRESS);
   assign w_up_act     = (w_up_press | (w_rep & ~key_up)) & key_down;
   assign w_dn_act     = (w_dn_press | (w_rep & ~key_down)) & key_up;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_mode <= 1'b1;
         r_key_up   <= 1'b1;
         r_key_down <= 1'b1;
         r_cnt      <= '0;
         r_ev_mode  <= 1'b0;
         r_ev_up    <= 1'b0;
         r_ev_dn    <= 1'b0;
      end else begin
         r_key_mode <= key_mode;
         r_key_up   <= key_up;
         r_key_down <= key_down;
         r_ev_mode  <= w_mode_press;
         r_ev_up    <= w_up_act;
         r_ev_dn    <= w_dn_act;
         if (!w_one_held)
            r_cnt <= '0;
         else if (w_up_press | w_dn_press)
            r_cnt <= 24'd1;
         else if (r_cnt == LONG_PRESS)
            r_cnt <= LONG_PRESS - REPEAT + 24'd1;
         else
            r_cnt <= r_cnt + 24'd1;
      end
   end

   always_comb begin
      w_fa    = r_freq_a;
      w_fb    = r_freq_b;
      w_wa    = r_wave_a;
      w_wb    = r_wave_b;
      w_ph    = r_phase_b;
      w_field = r_field;
      if (r_ev_mode) begin
         case (r_field)
            F_A:     w_field = W_A;
            W_A:     w_field = F_B;
            F_B:     w_field = W_B;
            W_B:     w_field = P_B;
            default: w_field = F_A;
         endcase
      end else if (r_ev_up | r_ev_dn) begin
         case (r_field)
            F_A:     w_fa    = r_ev_up ? freq_inc(r_freq_a) : freq_dec(r_freq_a);
            W_A:     w_wa    = r_ev_up ? r_wave_a + 2'd1 : r_wave_a - 2'd1;
            F_B:     w_fb    = r_ev_up ? freq_inc(r_freq_b) : freq_dec(r_freq_b);
            W_B:     w_wb    = r_ev_up ? r_wave_b + 2'd1 : r_wave_b - 2'd1;
            P_B:     w_ph    = r_ev_up ? r_phase_b + PH_STEP : r_phase_b - PH_STEP;
            default: w_field = F_A;
         endcase
      end
      w_chg = (w_fa != r_freq_a) | (w_fb != r_freq_b) | (w_wa != r_wave_a) |
              (w_wb != r_wave_b) | (w_ph != r_phase_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_freq_a  <= FREQ_INIT;
         r_freq_b  <= FREQ_INIT;
         r_wave_a  <= 2'd0;
         r_wave_b  <= 2'd0;
         r_phase_b <= '0;
         r_field   <= F_A;
         r_upd     <= 1'b0;
      end else begin
         r_freq_a  <= w_fa;
         r_freq_b  <= w_fb;
         r_wave_a  <= w_wa;
         r_wave_b  <= w_wb;
         r_phase_b <= w_ph;
         r_field   <= w_field;
         r_upd     <= w_chg;
      end
   end

   assign freq_word_a = r_freq_a;
   assign freq_word_b = r_freq_b;
   assign wave_sel_a  = r_wave_a;
   assign wave_sel_b  = r_wave_b;
   assign phase_b     = r_phase_b;
   assign edit_field  = r_field;
   assign cfg_update  = r_upd;

endmodule
